mono_rx_fifo_arbiter: RTL and testbench
=======================================

# mono_rx_fifo_arbiter

Round-robin packet arbiter that merges the 32-bit output FIFOs of N_SRC monopix receiver cores into one show-ahead FIFO stream for the readout bus. Each hit is a 3-word packet with headers bits[29:28] = 2'b01, 2'b10, 2'b11. The arbiter holds its grant on one source until that source's 2'b11 end word has been transferred, so packets from different chips never interleave. It sits between the per-chip receiver cores and the shared readout FIFO / SiTCP path, all in the BUS_CLK domain.

## Interface
- N_SRC, 4, number of receiver sources (2..8)
- TIMEOUT, 255, stall-cycle limit for a locked source; used only with MONO_ARB_TIMEOUT_EN (1..65535)

- BUS_CLK  in  1  sole clock, rising edge
- BUS_RST_N  in  1  reset, asynchronous assert, active-low
- ENABLE  in  N_SRC  per-source enable mask, sampled only during arbitration
- FIFO_EMPTY_IN  in  N_SRC  source i empty
- FIFO_DATA_IN  in  32*N_SRC  source i word at [32i+31:32i]; valid while its empty flag is low
- FIFO_READ_OUT  out  N_SRC  pop strobe to source i; combinational; one-hot or zero
- FIFO_READ  in  1  downstream pop
- FIFO_EMPTY  out  1  output empty
- FIFO_DATA  out  32  output word; valid while FIFO_EMPTY is low
- PACKET_CNT  out  16  count of end words transferred; saturates at 0xFFFF
- LOCK_ERROR  out  1  sticky timeout flag

## Operation
- Reset values:
  - FIFO_EMPTY=1, FIFO_DATA=0, FIFO_READ_OUT=0.
  - PACKET_CNT=0, LOCK_ERROR=0.
  - state=IDLE, grant=0, last_grant=N_SRC-1.
- Output stage is a 1-word register (data_q, valid_q).
  - FIFO_EMPTY = ~valid_q; FIFO_DATA = data_q.
  - can_load = ~valid_q | FIFO_READ.
- State IDLE:
  - Scan sources last_grant+1, last_grant+2, ... (mod N_SRC) for the first with ENABLE[i] & ~FIFO_EMPTY_IN[i].
  - If found: grant<=i, go to LOCKED.
  - No pops are issued in IDLE.
- State LOCKED:
  - FIFO_READ_OUT[grant] = can_load & ~FIFO_EMPTY_IN[grant].
  - On each pop: data_q<=word, valid_q<=1.
  - If the popped word has bits[29:28]==2'b11: PACKET_CNT++ (saturating), last_grant<=grant, go to IDLE.
  - If no pop and FIFO_READ is asserted, valid_q<=0.
- ENABLE deasserted mid-packet has no effect; the current packet completes.
- Words whose header is not 2'b11 are forwarded unchanged. Bits[31:30] (source identifier) pass through untouched.
- FIFO_READ while FIFO_EMPTY=1 is ignored.

## Timing
- Arbitration costs 1 cycle per packet.
  - Peak throughput: 3 words per 4 cycles.
  - With only one source active: back-to-back packets still pay the 1 IDLE cycle.
- Latency: a source becomes non-empty in IDLE at cycle 0.
  - Grant registered at edge 1.
  - Pop during cycle 1.
  - FIFO_EMPTY low after edge 2.
- Simultaneous downstream FIFO_READ and source pop in the same cycle: the register is replaced, with no bubble.
- Reset assertion mid-packet aborts immediately. The partially transferred packet is lost; sources are not popped during reset.
- With N_SRC=1 the block degenerates to a packet-framed pass-through with 1 idle cycle between packets.

## Configuration
- MONO_ARB_TIMEOUT_EN defined:
  - A 16-bit stall counter clears on every pop and on entry to LOCKED.
  - It increments in LOCKED each cycle FIFO_EMPTY_IN[grant]=1.
  - When it equals TIMEOUT: set LOCK_ERROR (sticky until reset), last_grant<=grant, go to IDLE. PACKET_CNT is not incremented.
  - Cycles stalled by a full output (source non-empty, can_load=0) do not count.
- MONO_ARB_TIMEOUT_EN not defined:
  - No counter is built; LOCKED waits indefinitely for the end word.
  - LOCK_ERROR is tied to 0.

## Test plan
- Single source: source 0 preloaded with words 0x1xxxxxxx/0x2xxxxxxx/0x3xxxxxxx (headers 01,10,11), FIFO_READ=1 constantly -> three words out in order; FIFO_EMPTY first low 2 cycles after release from IDLE; PACKET_CNT=1.
- Fairness: 4 sources each holding 2 packets, all enabled -> output source order 0,1,2,3,0,1,2,3; words of different sources never interleave; PACKET_CNT=8.
- Backpressure: FIFO_READ toggled 1-in-3 cycles during a packet -> no word dropped or duplicated; FIFO_READ_OUT never asserted while valid_q=1 & FIFO_READ=0.
- Enable mask: ENABLE=4'b1010 with all sources full -> only sources 1 and 3 served, alternately; clearing ENABLE[1] mid-packet -> that packet still completes.
- Timeout (macro on, TIMEOUT=16): source 2 supplies the 01 and 10 words then stays empty -> LOCK_ERROR=1 at exactly 16 empty cycles after the 2nd pop; arbiter returns to IDLE and serves source 3 next; without the macro the arbiter stays locked and LOCK_ERROR=0.
- Async reset: BUS_RST_N pulsed low mid-packet -> all outputs at reset values without a clock edge; the next packet arbitration starts from source 0.

Source files
------------

// File: rtl/mono_rx_fifo_arbiter_if.sv
// mono_rx_fifo_arbiter_if: per-source FIFO inputs and merged readout FIFO of the packet arbiter
interface mono_rx_fifo_arbiter_if #(parameter int N_SRC = 4);
  logic [N_SRC-1:0] ENABLE;
  logic [N_SRC-1:0] FIFO_EMPTY_IN;
  logic [32*N_SRC-1:0] FIFO_DATA_IN;
  logic [N_SRC-1:0] FIFO_READ_OUT;
  logic FIFO_READ;
  logic FIFO_EMPTY;
  logic [31:0] FIFO_DATA;
  modport master (
    input ENABLE, FIFO_EMPTY_IN, FIFO_DATA_IN, FIFO_READ,
    output FIFO_READ_OUT, FIFO_EMPTY, FIFO_DATA
  );
  modport slave (
    output ENABLE, FIFO_EMPTY_IN, FIFO_DATA_IN, FIFO_READ,
    input FIFO_READ_OUT, FIFO_EMPTY, FIFO_DATA
  );
endinterface

// File: rtl/mono_rx_fifo_arbiter.sv
// mono_rx_fifo_arbiter: round-robin, packet-framed merge of N_SRC receiver FIFOs into one show-ahead stream.
// MONO_ARB_TIMEOUT_EN adds a stall counter that abandons a source starved for TIMEOUT cycles and sets LOCK_ERROR.
module mono_rx_fifo_arbiter #(
  parameter int N_SRC = 4,
  parameter int TIMEOUT = 255
) (
  input logic BUS_CLK,
  input logic BUS_RST_N,
  mono_rx_fifo_arbiter_if.master bus,
  output logic [15:0] PACKET_CNT,
  output logic LOCK_ERROR
);
  localparam int GW = N_SRC > 1 ? $clog2(N_SRC) : 1;
  localparam logic [GW:0] NS = (GW+1)'(N_SRC);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] grant_q, grant_d, last_q, last_d, off;
  logic [GW:0] base, sum;
  logic [2*N_SRC-1:0] avail2;
  logic [N_SRC-1:0] rot;
  logic [31:0] src_w [N_SRC];
  logic [31:0] data_q, word;
  logic valid_q, can_load, pop, is_end, found, timeout;
  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    assign src_w[g] = bus.FIFO_DATA_IN[32*g +: 32];
  end
  assign can_load = ~valid_q | bus.FIFO_READ;
  assign word = src_w[grant_q];
  assign pop = (state_q == LOCKED) & can_load & ~bus.FIFO_EMPTY_IN[grant_q];
  assign is_end = pop & (word[29:28] == 2'b11);
  assign bus.FIFO_READ_OUT = pop ? N_SRC'(1) << grant_q : '0;
  assign bus.FIFO_EMPTY = ~valid_q;
  assign bus.FIFO_DATA = data_q;
  // Doubled request vector rotated so bit j is source (last_grant+1+j) mod N_SRC
  assign avail2 = {2{bus.ENABLE & ~bus.FIFO_EMPTY_IN}};
  assign base = {1'b0, last_q} + (GW+1)'(1);
  assign rot = N_SRC'(avail2 >> base);
  assign sum = base + {1'b0, off};
  always_comb begin
    off = '0;
    found = 1'b0;
    for (int j = N_SRC - 1; j >= 0; j--) if (rot[j]) begin off = GW'(j); found = 1'b1; end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    if (state_q == IDLE && found) begin
      state_d = LOCKED;
      grant_d = GW'(sum >= NS ? sum - NS : sum);
    end else if (state_q == LOCKED && (is_end || timeout)) begin
      state_d = IDLE;
      last_d = grant_q;
    end
  end
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= GW'(N_SRC - 1);
      data_q <= '0;
      valid_q <= 1'b0;
      PACKET_CNT <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      if (pop) begin
        data_q <= word;
        valid_q <= 1'b1;
      end else if (bus.FIFO_READ) valid_q <= 1'b0;
      if (is_end && PACKET_CNT != 16'hFFFF) PACKET_CNT <= PACKET_CNT + 16'd1;
    end
  end
`ifdef MONO_ARB_TIMEOUT_EN
  logic [15:0] stall_q;
  // Only starvation counts; cycles blocked by a full output register hold the count
  assign timeout = (state_q == LOCKED) & bus.FIFO_EMPTY_IN[grant_q] & (stall_q == 16'(TIMEOUT - 1));
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      stall_q <= '0;
      LOCK_ERROR <= 1'b0;
    end else begin
      stall_q <= (state_q != LOCKED || pop) ? '0 : bus.FIFO_EMPTY_IN[grant_q] ? stall_q + 16'd1 : stall_q;
      if (timeout) LOCK_ERROR <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign LOCK_ERROR = 1'b0;
`endif
endmodule

// File: tb/tb_mono_rx_fifo_arbiter.sv
// tb_mono_rx_fifo_arbiter: random packet traffic against a packet-level round-robin reference model.
module tb_mono_rx_fifo_arbiter;
  localparam int N = 4;
  localparam int TO = 16;
  logic BUS_CLK = 1'b0;
  logic BUS_RST_N = 1'b1;
  logic [15:0] PACKET_CNT;
  logic LOCK_ERROR;
  mono_rx_fifo_arbiter_if #(.N_SRC(N)) bus ();
  mono_rx_fifo_arbiter #(.N_SRC(N), .TIMEOUT(TO)) dut (
    .BUS_CLK(BUS_CLK),
    .BUS_RST_N(BUS_RST_N),
    .bus(bus),
    .PACKET_CNT(PACKET_CNT),
    .LOCK_ERROR(LOCK_ERROR)
  );
  always #5 BUS_CLK = ~BUS_CLK;
  logic [31:0] src_q[N][$];
  logic [31:0] mq[N][$];
  logic [31:0] exp_q[$];
  logic [N-1:0] en_mask, ro_s;
  logic emp_s, lock_s;
  logic [31:0] dat_s;
  logic [15:0] cnt_s;
  int n_assert = 0, n_fail = 0, mlast, exp_pkts;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  // One cycle: drive at negedge, sample 1ns later, retire source pops after posedge
  task automatic step(input logic rd);
    @(negedge BUS_CLK);
    bus.FIFO_READ = rd;
    bus.ENABLE = en_mask;
    for (int i = 0; i < N; i++) begin
      bus.FIFO_EMPTY_IN[i] = src_q[i].size() == 0;
      bus.FIFO_DATA_IN[32*i +: 32] = src_q[i].size() != 0 ? src_q[i][0] : $urandom;
    end
    #1;
    ro_s = bus.FIFO_READ_OUT;
    emp_s = bus.FIFO_EMPTY;
    dat_s = bus.FIFO_DATA;
    cnt_s = PACKET_CNT;
    lock_s = LOCK_ERROR;
    chk("read_out_onehot0", 32'($onehot0(ro_s)), 32'd1);
    if (!emp_s && !rd) chk("pop_while_full", 32'(ro_s), 32'd0);
    if (rd && !emp_s) begin
      if (exp_q.size() == 0) chk("extra_word_pending", 32'(exp_q.size()), 32'd1);
      else chk("data", dat_s, exp_q.pop_front());
    end
    @(posedge BUS_CLK);
    for (int i = 0; i < N; i++) if (ro_s[i]) begin
      chk("pop_nonempty", 32'(src_q[i].size() != 0), 32'd1);
      if (src_q[i].size() != 0) void'(src_q[i].pop_front());
    end
  endtask
  task automatic do_reset;
    @(negedge BUS_CLK);
    BUS_RST_N = 1'b0;
    bus.FIFO_EMPTY_IN = '1;
    bus.FIFO_DATA_IN = '0;
    bus.FIFO_READ = 1'b0;
    bus.ENABLE = '1;
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      mq[i].delete();
    end
    exp_q.delete();
    mlast = N - 1;
    exp_pkts = 0;
    en_mask = '1;
    repeat (2) @(negedge BUS_CLK);
    BUS_RST_N = 1'b1;
  endtask
  function automatic void load_pkt(int s);
    logic [31:0] w;
    for (int h = 1; h <= 3; h++) begin
      w = {2'(s), 2'(h), 28'($urandom)};
      src_q[s].push_back(w);
      mq[s].push_back(w);
    end
  endfunction
  // Reference: whole packets handed out round-robin after the last served source
  task automatic serve(input logic [N-1:0] mask, input int npk);
    int s;
    for (int p = 0; p < npk; p++) begin
      s = -1;
      for (int k = 1; k <= N && s < 0; k++)
        if (mask[(mlast + k) % N] && mq[(mlast + k) % N].size() != 0) s = (mlast + k) % N;
      if (s < 0) break;
      repeat (3) exp_q.push_back(mq[s].pop_front());
      mlast = s;
      exp_pkts++;
    end
  endtask
  task automatic run(input int mode, input int max_cyc, input int clr);
    for (int c = 0; c < max_cyc && exp_q.size() != 0; c++) begin
      step(mode == 0 ? 1'b1 : mode == 1 ? 1'(c % 3 == 0) : 1'($urandom_range(0, 1)));
      if (clr >= 0 && ro_s[clr]) begin
        en_mask[clr] = 1'b0;
        clr = -1;
      end
    end
    chk("drained", 32'(exp_q.size()), 32'd0);
    repeat (3) step(1'b1);
  endtask
  initial begin
    int pops, p, k;
    en_mask = '1;
    bus.ENABLE = '1;
    bus.FIFO_READ = 1'b0;
    bus.FIFO_EMPTY_IN = '1;
    bus.FIFO_DATA_IN = '0;
    #1 BUS_RST_N = 1'b0;
    #2;
    chk("rst_empty", 32'(bus.FIFO_EMPTY), 32'd1);
    chk("rst_data", bus.FIFO_DATA, 32'd0);
    chk("rst_read_out", 32'(bus.FIFO_READ_OUT), 32'd0);
    chk("rst_cnt", 32'(PACKET_CNT), 32'd0);
    chk("rst_lock", 32'(LOCK_ERROR), 32'd0);
    // single source: grant at edge 1, pop in cycle 1, output visible in cycle 2
    do_reset;
    load_pkt(0);
    serve('1, 1);
    step(1'b1);
    chk("idle_no_pop", 32'(ro_s), 32'd0);
    chk("empty_c0", 32'(emp_s), 32'd1);
    step(1'b1);
    chk("pop_c1", 32'(ro_s), 32'd1);
    chk("empty_c1", 32'(emp_s), 32'd1);
    step(1'b1);
    chk("empty_c2", 32'(emp_s), 32'd0);
    run(0, 20, -1);
    chk("cnt_single", 32'(cnt_s), 32'd1);
    // fairness with random downstream reads
    do_reset;
    for (int s = 0; s < N; s++) repeat (2) load_pkt(s);
    serve('1, 100);
    run(2, 400, -1);
    chk("cnt_fair", 32'(cnt_s), 32'(exp_pkts));
    // backpressure: one read every third cycle
    do_reset;
    for (int s = 0; s < N; s++) repeat ($urandom_range(1, 3)) load_pkt(s);
    serve('1, 100);
    run(1, 600, -1);
    chk("cnt_bp", 32'(cnt_s), 32'(exp_pkts));
    // enable mask 1010
    do_reset;
    en_mask = 4'b1010;
    for (int s = 0; s < N; s++) repeat (2) load_pkt(s);
    serve(4'b1010, 100);
    run(2, 300, -1);
    chk("cnt_mask", 32'(cnt_s), 32'(exp_pkts));
    chk("src0_untouched", 32'(src_q[0].size()), 32'd6);
    // ENABLE[1] dropped during source 1's packet: that packet still completes
    do_reset;
    en_mask = 4'b1010;
    for (int s = 0; s < N; s++) repeat (2) load_pkt(s);
    serve(4'b1010, 1);
    serve(4'b1000, 100);
    run(0, 200, 1);
    chk("cnt_mask_clr", 32'(cnt_s), 32'(exp_pkts));
    chk("src1_left", 32'(src_q[1].size()), 32'd3);
    // source 2 stalls after its 01 and 10 words
    do_reset;
    src_q[2].push_back({2'd2, 2'b01, 28'($urandom)});
    src_q[2].push_back({2'd2, 2'b10, 28'($urandom)});
    exp_q.push_back(src_q[2][0]);
    exp_q.push_back(src_q[2][1]);
    load_pkt(3);
`ifdef MONO_ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) exp_q.push_back(src_q[3][i]);
    pops = 0;
    p = -1;
    k = -1;
    for (int c = 0; c < 200 && (k < 0 || exp_q.size() != 0); c++) begin
      step(1'b1);
      if (lock_s && k < 0) k = c - p;
      if (ro_s[2]) begin
        pops++;
        if (pops == 2) p = c;
      end
    end
    // 16 starved cycles after the 2nd pop; the flag is seen in the cycle after them
    chk("timeout_delay", 32'(k), 32'(TO + 1));
    chk("lock_error_set", 32'(lock_s), 32'd1);
    chk("drained_after_timeout", 32'(exp_q.size()), 32'd0);
    chk("cnt_timeout", 32'(cnt_s), 32'd1);
`else
    pops = 0;
    p = 0;
    k = 0;
    repeat (60) step(1'b1);
    chk("lock_error_clear", 32'(lock_s), 32'd0);
    chk("partial_drained", 32'(exp_q.size()), 32'd0);
    chk("src3_waiting", 32'(src_q[3].size()), 32'd3);
    chk("cnt_locked", 32'(cnt_s), 32'd0);
`endif
    // asynchronous reset during the third packet
    do_reset;
    for (int s = 0; s < N; s++) load_pkt(s);
    serve('1, 100);
    for (int c = 0; c < 60; c++) begin
      step(1'b1);
      if (cnt_s == 16'd2 && ro_s != '0) break;
    end
    chk("mid_packet", 32'(cnt_s), 32'd2);
    #2 BUS_RST_N = 1'b0;
    #1;
    chk("arst_empty", 32'(bus.FIFO_EMPTY), 32'd1);
    chk("arst_data", bus.FIFO_DATA, 32'd0);
    chk("arst_read_out", 32'(bus.FIFO_READ_OUT), 32'd0);
    chk("arst_cnt", 32'(PACKET_CNT), 32'd0);
    chk("arst_lock", 32'(LOCK_ERROR), 32'd0);
    do_reset;
    for (int s = 0; s < N; s++) load_pkt(s);
    serve('1, 100);
    run(2, 300, -1);
    chk("cnt_after_reset", 32'(cnt_s), 32'(exp_pkts));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
